fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Drain side of the UART+FIFO datapath. Pops bytes from a show-ahead FIFO (combinational rdata, registered empty) and serialises each byte as an 8N1 UART frame on tx. Frames go out back-to-back while the FIFO is non-empty and en is high. Sits between the FIFO read port and the board TX pin.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 9600, line rate in bit/s; BIT_CYCLES = CLK_FREQ/BAUD (integer division, must be >= 2).
DATA_WIDTH, 8, frame payload width; only 8 is supported.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  transmit enable (flow control); sampled only in IDLE.
fifo_empty  in  1  FIFO empty flag, registered in the FIFO.
fifo_rdata  in  8  FIFO head word, valid combinationally while fifo_empty=0.
fifo_rd  out  1  FIFO pop strobe, one cycle per byte.
tx  out  1  serial line; idles high.
tx_busy  out  1  high while a frame (START..STOP) is in progress.
tx_done  out  1  one-cycle pulse on the last cycle of STOP.

Behaviour:
- States: IDLE, START, DATA, STOP. Internal counters: a bit-cycle counter (width $clog2(BIT_CYCLES)) and a bit index (0..7).
- Reset (asynchronous, any time including mid-frame): state=IDLE, tx=1, tx_busy=0, tx_done=0, fifo_rd=0, counters=0, shift register=0. The in-flight byte is lost; it is not re-popped.
- fifo_rd = (state==IDLE) & en & ~fifo_empty, combinational. It is never high in any other state and never high while fifo_empty=1.
- On the edge where fifo_rd=1: capture fifo_rdata into the shift register, clear the counters, and move to START.
- START: tx=0 for exactly BIT_CYCLES cycles, then DATA.
- DATA: shift-register bit 0 is driven on tx, LSB first. Each bit is held for BIT_CYCLES cycles, then the register shifts right and the bit index increments. After bit 7 completes, move to STOP.
- STOP: tx=1 for BIT_CYCLES cycles. tx_done=1 on the final STOP cycle, then IDLE.
- tx and tx_busy are registered and change on the same edge as the state. tx_busy=1 in START/DATA/STOP.
- Frame timing: start edge occurs 1 cycle after the fifo_rd cycle. The start bit to the end of the stop bit spans exactly 10*BIT_CYCLES cycles.
- Back-to-back frames: after STOP the block spends one IDLE cycle (the pop cycle), so the inter-frame gap is exactly 1 clk of extra idle-high.
- en low: stays in IDLE with no pops, tx=1. Deasserting en mid-frame does not abort the frame; it takes effect at the next IDLE.
- fifo_empty and fifo_rdata changes outside IDLE are ignored; the shift register holds the captured byte.
- Simultaneous FIFO write into an empty FIFO: fifo_empty is registered, so the pop occurs the cycle after empty falls. No pop is issued on stale data.

Test Plan:
- Use CLK_FREQ=1_000_000 and BAUD=100_000 (BIT_CYCLES=10) for all scenarios.
- Single byte: push 0x55, en=1 -> exactly one fifo_rd pulse. tx low for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10. tx_done pulses once at cycle 100 of the frame; tx_busy high for 100 cycles.
- Back-to-back: push 0xA3, 0x0F, 0xFF -> three fifo_rd pulses spaced 101 cycles apart. Decoded line bytes are 0xA3, 0x0F, 0xFF; fifo_empty ends at 1; no extra pop.
- Empty/enable gating: FIFO empty, or en=0 with 4 bytes queued, for 500 cycles -> fifo_rd never asserts and tx stays 1. Raising en starts the first frame with fifo_rd in the same cycle.
- en dropped mid-frame: deassert en during DATA bit 3 of 0xC6 -> the frame completes correctly, tx_done pulses, and no further pop occurs while en=0.
- Reset mid-frame: assert rst during DATA bit 5 -> tx=1, tx_busy=0, fifo_rd=0 immediately. After release with a byte queued, the next frame starts cleanly with a full 10-cycle start bit.
- FIFO full boundary: fill a 16-deep FIFO with 0x00..0x0F -> 16 frames are emitted in order. fifo_rd is never asserted after empty rises.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serialises each byte as an 8N1 UART frame on tx.
// One frame occupies 10*BIT_CYCLES cycles; consecutive frames are separated by a single idle (pop) cycle.
module fifo_uart_tx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_rd,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD;
   localparam int CNT_W      = $clog2(BIT_CYCLES);
   localparam int IDX_W      = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state_reg, state_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [IDX_W-1:0]      idx_reg, idx_next;
   logic [DATA_WIDTH-1:0] shift_reg, shift_next;
   logic                  tx_reg, tx_next;
   logic                  busy_reg, busy_next;
   logic                  bit_end;

   assign bit_end = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
         busy_reg  <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      tx_next    = tx_reg;
      busy_next  = busy_reg;
      fifo_rd    = 1'b0;
      tx_done    = 1'b0;

      case (state_reg)
         IDLE: begin
            cnt_next  = '0;
            tx_next   = 1'b1;
            busy_next = 1'b0;
            // rst gates the pop so a byte is never taken while the registers are held in reset
            if (en && !fifo_empty && !rst) begin
               fifo_rd    = 1'b1;
               shift_next = fifo_rdata;
               idx_next   = '0;
               state_next = START;
               tx_next    = 1'b0;
               busy_next  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_next   = '0;
               state_next = DATA;
               tx_next    = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_next = '0;
               if (idx_reg == IDX_LAST) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  // tx is registered, so it takes the bit that becomes bit 0 after this shift
                  shift_next = shift_reg >> 1;
                  idx_next   = idx_reg + 1'b1;
                  tx_next    = shift_reg[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               tx_done    = 1'b1;
               cnt_next   = '0;
               state_next = IDLE;
               busy_next  = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign tx      = tx_reg;
   assign tx_busy = busy_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: emulates a show-ahead FIFO and predicts every output cycle from the frame timing rules.
// Line bytes are also decoded mid-bit and compared against the push order.
module tb_fifo_uart_tx;

   localparam int BITC  = 10;
   localparam int FRAME = 10 * BITC;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic fifo_empty;
   logic [7:0] fifo_rdata;
   logic fifo_rd;
   logic tx;
   logic tx_busy;
   logic tx_done;

   fifo_uart_tx #(
      .CLK_FREQ  (1_000_000),
      .BAUD      (100_000),
      .DATA_WIDTH(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata),
      .fifo_rd   (fifo_rd),
      .tx        (tx),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_bytes[$];
   int checks = 0;
   int failures = 0;
   int pop_count = 0;
   int p0;

   // reference frame tracker: frame_k is the 1-based cycle index within the current frame
   bit frame_active = 1'b0;
   int frame_k = 0;
   logic [7:0] frame_byte = 8'h00;
   logic [7:0] rx_byte = 8'h00;
   logic rd_seen = 1'b0;
   logic exp_rd_cur = 1'b0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      exp_bytes.push_back(b);
   endtask

   task automatic check_cycle();
      logic e_rd, e_tx, e_busy, e_done;
      int b;
      if (!frame_active) begin
         e_rd   = en && !fifo_empty && !rst;
         e_tx   = 1'b1;
         e_busy = 1'b0;
         e_done = 1'b0;
      end else begin
         e_rd = 1'b0;
         b    = (frame_k - 1) / BITC;
         if (b == 0)
            e_tx = 1'b0;
         else if (b <= 8)
            e_tx = frame_byte[b-1];
         else
            e_tx = 1'b1;
         e_busy = 1'b1;
         e_done = (frame_k == FRAME);
         if (frame_k >= 15 && frame_k <= 85 && (frame_k % BITC) == 5)
            rx_byte[(frame_k - 15) / BITC] = tx;
      end
      chk("fifo_rd", {7'd0, fifo_rd}, {7'd0, e_rd});
      chk("tx", {7'd0, tx}, {7'd0, e_tx});
      chk("tx_busy", {7'd0, tx_busy}, {7'd0, e_busy});
      chk("tx_done", {7'd0, tx_done}, {7'd0, e_done});
      if (frame_active && frame_k == FRAME) begin
         if (exp_bytes.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL rx_extra: observed=%0h expected=none", rx_byte);
         end else begin
            chk("rx_byte", rx_byte, exp_bytes.pop_front());
         end
      end
      rd_seen    = fifo_rd;
      exp_rd_cur = e_rd;
   endtask

   task automatic update();
      if (frame_active) begin
         frame_k++;
         if (frame_k > FRAME) frame_active = 1'b0;
      end
      if (exp_rd_cur) begin
         frame_active = 1'b1;
         frame_k      = 1;
         frame_byte   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      end
      if (rd_seen) begin
         pop_count++;
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      fifo_empty = (fifo_q.size() == 0);
      fifo_rdata = fifo_empty ? 8'($urandom) : fifo_q[0];
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      update();
   endtask

   task automatic wait_k(input int target);
      int guard = 0;
      while (!(frame_active && frame_k == target) && guard < 2000) begin
         tick();
         guard++;
      end
      checks++;
      assert (guard < 2000) else begin
         failures++;
         $error("FAIL wait_k: observed=timeout expected=frame cycle %0d", target);
      end
   endtask

   task automatic drain();
      int guard = 0;
      while ((frame_active || !fifo_empty || fifo_q.size() > 0) && guard < 20000) begin
         tick();
         guard++;
      end
      repeat (5) tick();
      checks++;
      assert (guard < 20000) else begin
         failures++;
         $error("FAIL drain: observed=timeout expected=idle");
      end
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      fifo_empty = 1'b1;
      fifo_rdata = 8'h00;

      // reset state
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // single byte
      p0 = pop_count;
      push(8'h55);
      en = 1'b1;
      drain();
      chk("single_pops", 8'(pop_count - p0), 8'd1);

      // back-to-back frames
      p0 = pop_count;
      push(8'hA3);
      push(8'h0F);
      push(8'hFF);
      drain();
      chk("b2b_pops", 8'(pop_count - p0), 8'd3);
      chk("b2b_empty", {7'd0, fifo_empty}, 8'd1);

      // empty and enable gating
      repeat (100) tick();
      en = 1'b0;
      p0 = pop_count;
      for (int i = 0; i < 4; i++) push(8'($urandom));
      repeat (500) tick();
      chk("gate_pops", 8'(pop_count - p0), 8'd0);
      en = 1'b1;
      drain();
      chk("gate_drain_pops", 8'(pop_count - p0), 8'd4);

      // en dropped during data bit 3
      p0 = pop_count;
      push(8'hC6);
      push(8'($urandom));
      wait_k(44);
      en = 1'b0;
      repeat (250) tick();
      chk("endrop_pops", 8'(pop_count - p0), 8'd1);
      en = 1'b1;
      drain();

      // asynchronous reset during data bit 5
      push(8'($urandom));
      push(8'($urandom));
      wait_k(63);
      #1 rst = 1'b1;
      #1;
      chk("rst_tx", {7'd0, tx}, 8'd1);
      chk("rst_busy", {7'd0, tx_busy}, 8'd0);
      chk("rst_rd", {7'd0, fifo_rd}, 8'd0);
      chk("rst_done", {7'd0, tx_done}, 8'd0);
      frame_active = 1'b0;
      void'(exp_bytes.pop_front());
      repeat (3) tick();
      rst = 1'b0;
      drain();

      // sixteen queued bytes
      p0 = pop_count;
      for (int i = 0; i < 16; i++) push(8'(i));
      drain();
      chk("fill_pops", 8'(pop_count - p0), 8'd16);

      // random bytes with random enable gaps
      for (int i = 0; i < 6; i++) begin
         push(8'($urandom));
         en = 1'($urandom);
         repeat ($urandom_range(1, 150)) tick();
      end
      en = 1'b1;
      drain();
      chk("final_empty", {7'd0, fifo_empty}, 8'd1);
      chk("final_rx_left", 8'(exp_bytes.size()), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
